step_move_sched: RTL and testbench

Move scheduler for the stepper pulse generator. It accepts a queue of move commands (direction, step count, period) over the Avalon-MM slave. It then sequences the pulse generator: it loads period and direction, issues one-cycle start and stop strobes, and counts the generated step pulses until each move completes. It sits between the soft-CPU bus and the pulse-generator instance, replacing manual start/stop register pokes with back-to-back queued moves.

---
 rtl/step_move_sched_pkg.sv | 33 +++
 rtl/step_move_sched_cmd_fifo.sv | 67 ++++++
 rtl/step_move_sched.sv | 199 +++++++++++++++++++
 tb/tb_step_move_sched.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_move_sched_pkg.sv
// Shared types and constants for the stepper move scheduler: FSM states,
// register map, CTRL bit positions and the queued move command layout.
package step_move_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_PERIOD = 8'h02;
  localparam logic [7:0] ADDR_PUSH   = 8'h03;
  localparam logic [7:0] ADDR_REMAIN = 8'h04;
  localparam logic [7:0] ADDR_MOVES  = 8'h05;

  localparam int CTRL_GO    = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLR   = 2;
  localparam int CTRL_HALT  = 3;

  localparam int CMD_PERIOD_W = 16;
  localparam int CMD_STEPS_W  = 16;

  typedef struct packed {
    logic                    dir;
    logic [CMD_STEPS_W-1:0]  steps;
    logic [CMD_PERIOD_W-1:0] period;
  } cmd_t;

endpackage

// File: rtl/step_move_sched_cmd_fifo.sv
// Synchronous command FIFO with occupancy count and a single-cycle flush.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/step_move_sched.sv
// Move scheduler: queues {dir, steps, period} commands from the Avalon-MM slave
// and sequences the pulse generator with start/stop strobes, counting fed-back steps.
module step_move_sched
  import step_move_sched_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      avs_s0_address,
  input  logic [31:0]     avs_s0_writedata,
  input  logic            avs_s0_write,
  input  logic            avs_s0_read,
  output logic [31:0]     avs_s0_readdata,
  input  logic            drv_en_SM,
  input  logic            drv_pulse,
  output logic [SIZE-1:0] pg_period,
  output logic            pg_dir,
  output logic            pg_start,
  output logic            pg_stop,
  output logic            irq_done
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic             run_en_q, run_en_d;
  logic [SIZE-1:0]  period_stage_q, period_stage_d;
  logic [SIZE-1:0]  pg_period_q, pg_period_d;
  logic             pg_dir_q, pg_dir_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] moves_q, moves_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             skip_q, skip_d;
  logic             abort_stop_q, abort_stop_d;
  logic             pulse_sync_q, pulse_sync_d;
  logic             pulse_prev_q, pulse_prev_d;
  logic [31:0]      readdata_q, readdata_d;

  cmd_t             fifo_wdata, fifo_rdata;
  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;

  logic wr_ctrl, go, abort, clr, halt, push_req, wr_period, rise, done_set;
  logic unused_wd;

  assign wr_ctrl   = avs_s0_write && (avs_s0_address == ADDR_CTRL);
  assign go        = wr_ctrl && avs_s0_writedata[CTRL_GO];
  assign abort     = wr_ctrl && avs_s0_writedata[CTRL_ABORT];
  assign clr       = wr_ctrl && avs_s0_writedata[CTRL_CLR];
  assign halt      = wr_ctrl && avs_s0_writedata[CTRL_HALT];
  assign push_req  = avs_s0_write && (avs_s0_address == ADDR_PUSH);
  assign wr_period = avs_s0_write && (avs_s0_address == ADDR_PERIOD);
  assign rise      = pulse_sync_q && !pulse_prev_q;
  assign unused_wd = ^avs_s0_writedata;

  assign fifo_wdata = {avs_s0_writedata[31],
                       CMD_STEPS_W'(avs_s0_writedata[CNT_W-1:0]),
                       CMD_PERIOD_W'(period_stage_q)};
  assign fifo_push  = push_req;
  assign fifo_flush = abort;
  assign fifo_pop   = (state_q == ST_LOAD) && !abort;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign avs_s0_readdata = readdata_q;
  assign pg_period       = pg_period_q;
  assign pg_dir          = pg_dir_q;
  assign pg_start        = (state_q == ST_START);
  assign pg_stop         = abort_stop_q || ((state_q == ST_STOP) && !skip_q);
  assign irq_done        = done_q;

  always_comb begin
    state_d        = state_q;
    run_en_d       = run_en_q;
    period_stage_d = period_stage_q;
    pg_period_d    = pg_period_q;
    pg_dir_d       = pg_dir_q;
    remaining_d    = remaining_q;
    moves_d        = moves_q;
    skip_d         = skip_q;
    ovf_d          = ovf_q;
    done_set       = 1'b0;
    pulse_sync_d   = drv_pulse;
    pulse_prev_d   = pulse_sync_q;
    abort_stop_d   = abort && ((state_q == ST_START) || (state_q == ST_RUN));

    if (go)                  run_en_d = 1'b1;
    if (halt || abort)       run_en_d = 1'b0;
    if (wr_period)           period_stage_d = avs_s0_writedata[SIZE-1:0];
    if (clr)                 ovf_d = 1'b0;
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (run_en_q && !fifo_empty && drv_en_SM) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pg_period_d = SIZE'(fifo_rdata.period);
        pg_dir_d    = fifo_rdata.dir;
        remaining_d = CNT_W'(fifo_rdata.steps);
        skip_d      = (fifo_rdata.steps == '0);
        state_d     = (fifo_rdata.steps == '0) ? ST_STOP : ST_START;
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        // The STOP transition lags the final decrement by one cycle.
        if (drv_en_SM) begin
          if (remaining_q == '0) state_d = ST_STOP;
          else if (rise)         remaining_d = remaining_q - 1'b1;
        end
      end
      ST_STOP: begin
        moves_d = moves_q + 1'b1;
        if (run_en_q && !fifo_empty) begin
          state_d = ST_LOAD;
        end else begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      moves_d     = moves_q;
      pg_period_d = pg_period_q;
      pg_dir_d    = pg_dir_q;
      done_set    = 1'b0;
    end

    done_d = (done_q && !clr) || done_set;

    readdata_d = readdata_q;
    if (avs_s0_read) begin
      unique case (avs_s0_address)
        ADDR_CTRL:   readdata_d = {16'h0, 8'(fifo_count), 1'b0, state_q,
                                   ovf_q, done_q, fifo_full, fifo_empty};
        ADDR_REMAIN: readdata_d = 32'(remaining_q);
        ADDR_MOVES:  readdata_d = 32'(moves_q);
        default:     readdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      run_en_q       <= 1'b0;
      period_stage_q <= '0;
      pg_period_q    <= '0;
      pg_dir_q       <= 1'b0;
      remaining_q    <= '0;
      moves_q        <= '0;
      done_q         <= 1'b0;
      ovf_q          <= 1'b0;
      skip_q         <= 1'b0;
      abort_stop_q   <= 1'b0;
      pulse_sync_q   <= 1'b0;
      pulse_prev_q   <= 1'b0;
      readdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      run_en_q       <= run_en_d;
      period_stage_q <= period_stage_d;
      pg_period_q    <= pg_period_d;
      pg_dir_q       <= pg_dir_d;
      remaining_q    <= remaining_d;
      moves_q        <= moves_d;
      done_q         <= done_d;
      ovf_q          <= ovf_d;
      skip_q         <= skip_d;
      abort_stop_q   <= abort_stop_d;
      pulse_sync_q   <= pulse_sync_d;
      pulse_prev_q   <= pulse_prev_d;
      readdata_q     <= readdata_d;
    end
  end

endmodule

// File: tb/tb_step_move_sched.sv
// Self-checking bench for step_move_sched: register table, directed move
// sequences, and randomized move queues checked against a queue-based model.
module tb_step_move_sched;
  import step_move_sched_pkg::*;

  localparam int SIZE  = 16;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      avs_s0_address = '0;
  logic [31:0]     avs_s0_writedata = '0;
  logic            avs_s0_write = 1'b0;
  logic            avs_s0_read = 1'b0;
  logic [31:0]     avs_s0_readdata;
  logic            drv_en_SM = 1'b1;
  logic            drv_pulse = 1'b0;
  logic [SIZE-1:0] pg_period;
  logic            pg_dir, pg_start, pg_stop, irq_done;

  always #10 clk = ~clk;

  step_move_sched #(.SIZE(SIZE), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .avs_s0_address   (avs_s0_address),
    .avs_s0_writedata (avs_s0_writedata),
    .avs_s0_write     (avs_s0_write),
    .avs_s0_read      (avs_s0_read),
    .avs_s0_readdata  (avs_s0_readdata),
    .drv_en_SM        (drv_en_SM),
    .drv_pulse        (drv_pulse),
    .pg_period        (pg_period),
    .pg_dir           (pg_dir),
    .pg_start         (pg_start),
    .pg_stop          (pg_stop),
    .irq_done         (irq_done)
  );

  int vectors = 0;
  int miscompares = 0;
  int strays = 0;
  int expMoves = 0;

  typedef struct {
    bit          isRead;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] expd;
  } vec_t;

  typedef struct {
    int          steps;
    logic [15:0] per;
    logic        dir;
  } mv_t;

  vec_t vecs[19];
  mv_t  model[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expd);
    vectors++;
    if (act !== expd) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expd);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic busWrite(input logic [7:0] addr, input logic [31:0] data);
    avs_s0_address   = addr;
    avs_s0_writedata = data;
    avs_s0_write     = 1'b1;
    @(negedge clk);
    avs_s0_write     = 1'b0;
  endtask

  task automatic busRead(input logic [7:0] addr, output logic [31:0] data);
    avs_s0_address = addr;
    avs_s0_read    = 1'b1;
    @(negedge clk);
    avs_s0_read    = 1'b0;
    data           = avs_s0_readdata;
  endtask

  task automatic readCheck(input string name, input logic [7:0] addr, input logic [31:0] expd);
    logic [31:0] rd;
    busRead(addr, rd);
    checkOutput(name, rd, expd);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] rd;
    if (v.isRead) begin
      busRead(v.addr, rd);
      checkOutput($sformatf("vec%0d", idx), rd, v.expd);
    end else begin
      busWrite(v.addr, v.data);
    end
  endtask

  task automatic waitStart(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (pg_stop) strays++;
      if (pg_start) begin
        cyc = i;
        break;
      end
    end
  endtask

  // One-cycle step pulse; reports the falling edge (1..4) at which pg_stop was seen.
  task automatic pulseOnce(output int stopAt);
    stopAt    = 0;
    drv_pulse = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drv_pulse = 1'b0;
      if (pg_stop && stopAt == 0) stopAt = i;
      if (pg_start) strays++;
    end
  endtask

  task automatic idleWatch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pg_start || pg_stop) strays++;
    end
  endtask

  task automatic runMove(input int steps, input logic [15:0] per, input logic dir,
                         output int tail, output int cyc);
    int stopAt, used;
    tail = 0;
    waitStart(cyc);
    checkOutput("start_seen", 32'(cyc > 0), 32'd1);
    if (cyc > 0) begin
      checkOutput("pg_period", 32'(pg_period), 32'(per));
      checkOutput("pg_dir", 32'(pg_dir), 32'(dir));
      used   = 0;
      stopAt = 0;
      while (stopAt == 0 && used < steps + 1) begin
        pulseOnce(stopAt);
        used++;
      end
      checkOutput("pulses_to_stop", 32'(used), 32'(steps));
      checkOutput("edge_to_stop", 32'(stopAt), 32'd3);
      tail = 4 - stopAt;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int tail, cyc, tail2, stopAt, nMoves;
    logic [31:0] stat;

    vecs[0]  = '{1'b1, ADDR_CTRL,   32'h0,          32'h0000_0001};
    vecs[1]  = '{1'b1, ADDR_REMAIN, 32'h0,          32'h0};
    vecs[2]  = '{1'b1, ADDR_MOVES,  32'h0,          32'h0};
    vecs[3]  = '{1'b1, 8'h07,       32'h0,          32'h0};
    vecs[4]  = '{1'b0, ADDR_PERIOD, 32'd100,        32'h0};
    vecs[5]  = '{1'b0, ADDR_PUSH,   32'h8000_0003,  32'h0};
    vecs[6]  = '{1'b1, ADDR_CTRL,   32'h0,          32'h0000_0100};
    vecs[7]  = '{1'b0, ADDR_PUSH,   32'h0000_0002,  32'h0};
    vecs[8]  = '{1'b0, ADDR_PUSH,   32'h0000_0001,  32'h0};
    vecs[9]  = '{1'b0, ADDR_PUSH,   32'h8000_0004,  32'h0};
    vecs[10] = '{1'b1, ADDR_CTRL,   32'h0,          32'h0000_0402};
    vecs[11] = '{1'b0, ADDR_PUSH,   32'h0000_0007,  32'h0};
    vecs[12] = '{1'b1, ADDR_CTRL,   32'h0,          32'h0000_040A};
    vecs[13] = '{1'b0, ADDR_CTRL,   32'h0000_0004,  32'h0};
    vecs[14] = '{1'b1, ADDR_CTRL,   32'h0,          32'h0000_0402};
    vecs[15] = '{1'b0, ADDR_CTRL,   32'h0000_0002,  32'h0};
    vecs[16] = '{1'b0, 8'h09,       32'hFFFF_FFFF,  32'h0};
    vecs[17] = '{1'b1, ADDR_CTRL,   32'h0,          32'h0000_0001};
    vecs[18] = '{1'b1, 8'h01,       32'h0,          32'h0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_pg_start", 32'(pg_start), 32'd0);
    checkOutput("rst_pg_stop", 32'(pg_stop), 32'd0);
    checkOutput("rst_pg_period", 32'(pg_period), 32'd0);
    checkOutput("rst_pg_dir", 32'(pg_dir), 32'd0);
    checkOutput("rst_irq_done", 32'(irq_done), 32'd0);
    checkOutput("rst_readdata", avs_s0_readdata, 32'd0);

    $display("[TB] register table");
    for (int i = 0; i < 19; i++) applyStimulus(vecs[i], i);

    $display("[TB] single move: period 100, dir 1, 3 steps");
    busWrite(ADDR_PERIOD, 32'd100);
    busWrite(ADDR_PUSH, 32'h8000_0003);
    busWrite(ADDR_CTRL, 32'h1);
    waitStart(cyc);
    checkOutput("go_to_start", 32'(cyc), 32'd2);
    checkOutput("pg_period_100", 32'(pg_period), 32'd100);
    checkOutput("pg_dir_1", 32'(pg_dir), 32'd1);
    pulseOnce(stopAt);
    checkOutput("edge1_no_stop", 32'(stopAt), 32'd0);
    pulseOnce(stopAt);
    checkOutput("edge2_no_stop", 32'(stopAt), 32'd0);
    pulseOnce(stopAt);
    checkOutput("edge3_stop_at_3", 32'(stopAt), 32'd3);
    expMoves = 1;
    checkOutput("irq_done_set", 32'(irq_done), 32'd1);
    readCheck("status_done", ADDR_CTRL, 32'h0000_0005);
    readCheck("moves_1", ADDR_MOVES, 32'(expMoves));

    $display("[TB] zero-step move between two moves");
    busWrite(ADDR_CTRL, 32'hC);
    busWrite(ADDR_PERIOD, 32'd200);
    busWrite(ADDR_PUSH, 32'h0000_0002);
    busWrite(ADDR_PERIOD, 32'd300);
    busWrite(ADDR_PUSH, 32'h0000_0000);
    busWrite(ADDR_PERIOD, 32'd400);
    busWrite(ADDR_PUSH, 32'h8000_0001);
    busWrite(ADDR_CTRL, 32'h1);
    runMove(2, 16'd200, 1'b0, tail, cyc);
    runMove(1, 16'd400, 1'b1, tail, cyc);
    idleWatch(4);
    expMoves += 3;
    checkOutput("zero_step_no_strobes", 32'(strays), 32'd0);
    readCheck("moves_after_zero", ADDR_MOVES, 32'(expMoves));

    $display("[TB] back-to-back gap");
    busWrite(ADDR_CTRL, 32'hC);
    busWrite(ADDR_PERIOD, 32'd10);
    busWrite(ADDR_PUSH, 32'h0000_0001);
    busWrite(ADDR_PERIOD, 32'd20);
    busWrite(ADDR_PUSH, 32'h0000_0001);
    busWrite(ADDR_CTRL, 32'h1);
    runMove(1, 16'd10, 1'b0, tail, cyc);
    runMove(1, 16'd20, 1'b0, tail2, cyc);
    checkOutput("stop_to_start_gap", 32'(tail + cyc), 32'd2);
    expMoves += 2;

    $display("[TB] halt during run");
    busWrite(ADDR_CTRL, 32'hC);
    busWrite(ADDR_PERIOD, 32'd30);
    busWrite(ADDR_PUSH, 32'h0000_0001);
    busWrite(ADDR_PERIOD, 32'd40);
    busWrite(ADDR_PUSH, 32'h0000_0001);
    busWrite(ADDR_CTRL, 32'h1);
    waitStart(cyc);
    checkOutput("halt_start_seen", 32'(cyc > 0), 32'd1);
    busWrite(ADDR_CTRL, 32'h8);
    pulseOnce(stopAt);
    checkOutput("halt_move_finishes", 32'(stopAt), 32'd3);
    idleWatch(8);
    expMoves += 1;
    checkOutput("halt_no_next_start", 32'(strays), 32'd0);
    readCheck("halt_status", ADDR_CTRL, 32'h0000_0104);
    readCheck("halt_moves", ADDR_MOVES, 32'(expMoves));
    busWrite(ADDR_CTRL, 32'h2);
    checkOutput("idle_abort_no_stop", 32'(pg_stop), 32'd0);

    $display("[TB] abort after 2 of 5 pulses");
    busWrite(ADDR_CTRL, 32'hC);
    busWrite(ADDR_PERIOD, 32'd50);
    busWrite(ADDR_PUSH, 32'h0000_0005);
    busWrite(ADDR_PUSH, 32'h0000_0002);
    busWrite(ADDR_CTRL, 32'h1);
    waitStart(cyc);
    checkOutput("abort_start_seen", 32'(cyc > 0), 32'd1);
    pulseOnce(stopAt);
    pulseOnce(stopAt);
    readCheck("remaining_3", ADDR_REMAIN, 32'd3);
    busWrite(ADDR_CTRL, 32'h2);
    checkOutput("abort_stop_pulse", 32'(pg_stop), 32'd1);
    @(negedge clk);
    checkOutput("abort_stop_one_cycle", 32'(pg_stop), 32'd0);
    readCheck("abort_status", ADDR_CTRL, 32'h0000_0001);
    readCheck("abort_remaining", ADDR_REMAIN, 32'd0);
    checkOutput("abort_irq_low", 32'(irq_done), 32'd0);
    readCheck("abort_moves", ADDR_MOVES, 32'(expMoves));

    $display("[TB] asynchronous reset mid-run");
    busWrite(ADDR_PERIOD, 32'd60);
    busWrite(ADDR_PUSH, 32'h8000_0005);
    busWrite(ADDR_CTRL, 32'h1);
    waitStart(cyc);
    pulseOnce(stopAt);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_pg_period", 32'(pg_period), 32'd0);
    checkOutput("arst_pg_dir", 32'(pg_dir), 32'd0);
    checkOutput("arst_pg_start", 32'(pg_start), 32'd0);
    checkOutput("arst_pg_stop", 32'(pg_stop), 32'd0);
    checkOutput("arst_readdata", avs_s0_readdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    readCheck("arst_status", ADDR_CTRL, 32'h0000_0001);
    readCheck("arst_moves", ADDR_MOVES, 32'd0);
    expMoves = 0;

    $display("[TB] randomized move queues");
    for (int t = 0; t < 6; t++) begin
      busWrite(ADDR_CTRL, 32'hC);
      model.delete();
      nMoves = $urandom_range(1, DEPTH);
      for (int m = 0; m < nMoves; m++) begin
        mv_t mv;
        mv.steps = $urandom_range(0, 3);
        mv.per   = 16'($urandom_range(1, 65535));
        mv.dir   = 1'($urandom_range(0, 1));
        model.push_back(mv);
        busWrite(ADDR_PERIOD, 32'(mv.per));
        busWrite(ADDR_PUSH, {mv.dir, 15'h0, 16'(mv.steps)});
      end
      busWrite(ADDR_CTRL, 32'h1);
      while (model.size() > 0) begin
        mv_t mv;
        mv = model.pop_front();
        if (mv.steps != 0) runMove(mv.steps, mv.per, mv.dir, tail, cyc);
        expMoves++;
      end
      idleWatch(12);
      checkOutput("rand_no_stray_strobes", 32'(strays), 32'd0);
      busRead(ADDR_CTRL, stat);
      checkOutput("rand_status", stat, 32'h0000_0005);
      readCheck("rand_moves", ADDR_MOVES, 32'(expMoves));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
